decode_imm_stage: RTL and testbench

DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/imm_decode.sv | 132 +++++++++++++
 rtl/decode_imm_stage.sv | 160 ++++++++++++++++
 tb/tb_decode_imm_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/immediate stage:
//   - fmt_e      : instruction format codes carried on out_fmt
//   - OPC_*      : RISC-V major opcode constants
//   - rv64_ops_legal() : tells whether the RV64-only "W" opcodes
//                        (OP-IMM-32, OP-32) are legal for a given XLEN
// No ports (package).
// ---------------------------------------------------------------------------
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6,
        FMT_X = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // The word-sized ALU opcodes only exist on a 64-bit datapath.
    function automatic logic rv64_ops_legal(input int xlen);
        return (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational opcode decode and immediate extraction.
// Optional feature macro: DECODE_IMM_ZICSR_EN (decode SYSTEM/CSR opcodes).
// Ports:
//   instr   in  32    raw instruction word
//   imm     out XLEN  sign-extended immediate (0 for R and illegal)
//   fmt     out 3     instruction format code (fmt_e)
//   illegal out 1     opcode not recognised for this build/XLEN
// ---------------------------------------------------------------------------
module imm_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam logic WIDE_OK = rv64_ops_legal(XLEN);

    logic [6:0]  opcode;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [31:0] imm32;

    // Every RISC-V immediate fits in 32 bits, so each format is assembled as
    // a 32-bit value whose bit 31 already carries the sign; widening to XLEN
    // is then a single signed cast.  This also gives U-type its sign
    // extension above bit 31 on a 64-bit datapath.
    assign opcode = instr[6:0];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};
    assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef DECODE_IMM_ZICSR_EN
    logic [2:0]  funct3;
    logic [31:0] z_imm;

    assign funct3 = instr[14:12];
    assign z_imm  = {27'b0, instr[19:15]};
`endif

    // Format selection.  Anything not explicitly recognised falls through to
    // the defaults: format X, zero immediate and the illegal flag set.  The
    // beat itself is never suppressed here; the stage downstream delivers it.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_X;
        illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm32   = i_imm;
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            OPC_STORE: begin
                imm32   = s_imm;
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            OPC_BRANCH: begin
                imm32   = b_imm;
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = u_imm;
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            OPC_JAL: begin
                imm32   = j_imm;
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            OPC_OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            OPC_OP_IMM_32: begin
                if (WIDE_OK) begin
                    imm32   = i_imm;
                    fmt     = FMT_I;
                    illegal = 1'b0;
                end
            end
            OPC_OP_32: begin
                if (WIDE_OK) begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
            end
`ifdef DECODE_IMM_ZICSR_EN
            OPC_SYSTEM: begin
                case (funct3)
                    3'b001, 3'b010, 3'b011: begin
                        imm32   = i_imm;
                        fmt     = FMT_I;
                        illegal = 1'b0;
                    end
                    3'b101, 3'b110, 3'b111: begin
                        imm32   = z_imm;
                        fmt     = FMT_Z;
                        illegal = 1'b0;
                    end
                    default: begin
                        imm32   = '0;
                        fmt     = FMT_X;
                        illegal = 1'b1;
                    end
                endcase
            end
`endif
            default: begin
                imm32   = '0;
                fmt     = FMT_X;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_imm_stage.sv
// ---------------------------------------------------------------------------
// decode_imm_stage
// One pipeline stage that decodes the instruction format and immediate and
// registers the result behind a 2-entry (main + skid) valid/ready buffer.
// Optional feature macro: DECODE_IMM_ZICSR_EN (passed through to imm_decode).
// Ports:
//   clk, rst (sync, active-high), flush (drop everything held)
//   upstream  : in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0]
//   downstream: out_valid, out_ready, out_instr[31:0], out_pc[XLEN-1:0],
//               out_imm[XLEN-1:0], out_fmt[2:0], out_illegal
// ---------------------------------------------------------------------------
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    logic            main_valid;
    logic [31:0]     main_instr;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_imm;
    fmt_e            main_fmt;
    logic            main_illegal;

    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    fmt_e            skid_fmt;
    logic            skid_illegal;

    logic            in_ready_q;
    logic            accept;
    logic            complete;
    logic            main_valid_nxt;
    logic            skid_valid_nxt;
    logic            load_main_from_in;
    logic            load_main_from_skid;
    logic            load_skid;

    imm_decode #(
        .XLEN(XLEN)
    ) u_imm_decode (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    assign accept   = in_valid && in_ready_q;
    assign complete = main_valid && out_ready;

    // Buffer steering.  Main is "free" when empty or draining this cycle; a
    // free main first refills from skid (older beat) and otherwise straight
    // from the input, so a beat normally sees one cycle of latency and a
    // simultaneous accept+complete swaps main with no bubble.  Only when main
    // is stuck does a new beat park in skid.  in_ready is low whenever skid
    // is occupied, so an accept and a skid-to-main move never coincide.
    always_comb begin
        main_valid_nxt      = main_valid;
        skid_valid_nxt      = skid_valid;
        load_main_from_in   = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;
        if (!main_valid || complete) begin
            if (skid_valid) begin
                load_main_from_skid = 1'b1;
                main_valid_nxt      = 1'b1;
                skid_valid_nxt      = 1'b0;
            end else if (accept) begin
                load_main_from_in   = 1'b1;
                main_valid_nxt      = 1'b1;
            end else begin
                main_valid_nxt      = 1'b0;
            end
        end else if (accept) begin
            load_skid      = 1'b1;
            skid_valid_nxt = 1'b1;
        end
    end

    // State and payload registers.  Reset wins over flush, and flush wins
    // over any handshake: a beat offered alongside flush is simply ignored.
    // Payload fields are left untouched by flush since the valids cover them.
    // in_ready is registered from the next skid state so it always equals
    // the inverse of the registered skid_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            in_ready_q   <= 1'b1;
            main_instr   <= '0;
            main_pc      <= '0;
            main_imm     <= '0;
            main_fmt     <= FMT_R;
            main_illegal <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_R;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready_q <= !skid_valid_nxt;
            if (load_main_from_skid) begin
                main_instr   <= skid_instr;
                main_pc      <= skid_pc;
                main_imm     <= skid_imm;
                main_fmt     <= skid_fmt;
                main_illegal <= skid_illegal;
            end else if (load_main_from_in) begin
                main_instr   <= in_instr;
                main_pc      <= in_pc;
                main_imm     <= dec_imm;
                main_fmt     <= dec_fmt;
                main_illegal <= dec_illegal;
            end
            if (load_skid) begin
                skid_instr   <= in_instr;
                skid_pc      <= in_pc;
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid;
    assign out_instr   = main_instr;
    assign out_pc      = main_pc;
    assign out_imm     = main_imm;
    assign out_fmt     = main_fmt;
    assign out_illegal = main_illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_imm_stage
// Directed self-checking bench for decode_imm_stage.  Two instances share the
// same stimulus: one at XLEN=32 and one at XLEN=64.
// Optional feature macro: DECODE_IMM_ZICSR_EN changes the CSR expectations.
// ---------------------------------------------------------------------------
module tb_decode_imm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc32;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        in_ready32;
    logic        o32_valid;
    logic [31:0] o32_instr;
    logic [31:0] o32_pc;
    logic [31:0] o32_imm;
    logic [2:0]  o32_fmt;
    logic        o32_illegal;

    logic        in_ready64;
    logic        o64_valid;
    logic [31:0] o64_instr;
    logic [63:0] o64_pc;
    logic [63:0] o64_imm;
    logic [2:0]  o64_fmt;
    logic        o64_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_imm_stage #(.XLEN(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_instr   (in_instr),
        .in_pc      (in_pc32),
        .out_valid  (o32_valid),
        .out_ready  (out_ready),
        .out_instr  (o32_instr),
        .out_pc     (o32_pc),
        .out_imm    (o32_imm),
        .out_fmt    (o32_fmt),
        .out_illegal(o32_illegal)
    );

    decode_imm_stage #(.XLEN(64)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (in_instr),
        .in_pc      (in_pc64),
        .out_valid  (o64_valid),
        .out_ready  (out_ready),
        .out_instr  (o64_instr),
        .out_pc     (o64_pc),
        .out_imm    (o64_imm),
        .out_fmt    (o64_fmt),
        .out_illegal(o64_illegal)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'hFFFF_FFFF;
        in_pc32 = 32'h0; in_pc64 = 64'h0; out_ready = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", o32_valid); end
        checks++; if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready32); end
        checks++; if (o32_imm !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_imm got %h want 0", o32_imm); end
        checks++; if (o32_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc got %h want 0", o32_pc); end
        checks++; if (o32_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr got %h want 0", o32_instr); end
        checks++; if (o32_fmt !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_fmt got %0d want 0", o32_fmt); end
        checks++; if (o32_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_illegal got %b want 0", o32_illegal); end
        checks++; if (o64_valid !== 1'b0 || in_ready64 !== 1'b1 || o64_imm !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_x64 got valid=%b ready=%b imm=%h want 0/1/0", o64_valid, in_ready64, o64_imm);
        end
    endtask

    task automatic test_decode32();
        logic [31:0] vin   [11];
        logic [31:0] vimm  [11];
        logic [2:0]  vfmt  [11];
        logic        vill  [11];
        vin  = '{32'h00500093, 32'hFE208EE3, 32'h010000EF, 32'h00112423, 32'h123450B7, 32'h002081B3,
                 32'hFFF00093, 32'hFFFFFFFF, 32'h0000001B, 32'hFE112E23, 32'hFFFFF097};
        vimm = '{32'h00000005, 32'hFFFFFFFC, 32'h00000010, 32'h00000008, 32'h12345000, 32'h00000000,
                 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFF000};
        vfmt = '{3'd1, 3'd3, 3'd5, 3'd2, 3'd4, 3'd0, 3'd1, 3'd7, 3'd7, 3'd2, 3'd4};
        vill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_instr = vin[i];
            in_pc32  = 32'h0000_1000 + 32'(i * 4);
            in_pc64  = 64'h0;
            step();
            in_valid = 1'b0;
            checks++; if (o32_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec32_valid[%0d] got %b want 1", i, o32_valid); end
            checks++; if (o32_imm !== vimm[i]) begin errors++; $display("[TB] FAIL dec32_imm[%0d] got %h want %h", i, o32_imm, vimm[i]); end
            checks++; if (o32_fmt !== vfmt[i]) begin errors++; $display("[TB] FAIL dec32_fmt[%0d] got %0d want %0d", i, o32_fmt, vfmt[i]); end
            checks++; if (o32_illegal !== vill[i]) begin errors++; $display("[TB] FAIL dec32_illegal[%0d] got %b want %b", i, o32_illegal, vill[i]); end
            checks++; if (o32_instr !== vin[i] || o32_pc !== 32'h0000_1000 + 32'(i * 4)) begin
                errors++; $display("[TB] FAIL dec32_payload[%0d] got instr=%h pc=%h want %h/%h", i, o32_instr, o32_pc, vin[i], 32'h0000_1000 + 32'(i * 4));
            end
        end
        step();
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec32_drain got %b want 0", o32_valid); end
    endtask

    task automatic test_xlen64();
        logic [31:0] vin   [5];
        logic [63:0] vimm  [5];
        logic [2:0]  vfmt  [5];
        logic        vill  [5];
        logic        vill32[5];
        vin    = '{32'h800000B7, 32'h0000001B, 32'hFFF00093, 32'h0000003B, 32'hFE208EE3};
        vimm   = '{64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFC};
        vfmt   = '{3'd4, 3'd1, 3'd1, 3'd0, 3'd3};
        vill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vill32 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = vin[i];
            in_pc32  = 32'h0;
            in_pc64  = 64'h8000_0000_0000_2000 + 64'(i * 4);
            step();
            in_valid = 1'b0;
            checks++; if (o64_valid !== 1'b1 || o64_imm !== vimm[i]) begin
                errors++; $display("[TB] FAIL dec64_imm[%0d] got valid=%b imm=%h want 1/%h", i, o64_valid, o64_imm, vimm[i]);
            end
            checks++; if (o64_fmt !== vfmt[i] || o64_illegal !== vill[i]) begin
                errors++; $display("[TB] FAIL dec64_fmt[%0d] got fmt=%0d ill=%b want %0d/%b", i, o64_fmt, o64_illegal, vfmt[i], vill[i]);
            end
            checks++; if (o64_pc !== 64'h8000_0000_0000_2000 + 64'(i * 4)) begin
                errors++; $display("[TB] FAIL dec64_pc[%0d] got %h want %h", i, o64_pc, 64'h8000_0000_0000_2000 + 64'(i * 4));
            end
            checks++; if (o32_illegal !== vill32[i]) begin
                errors++; $display("[TB] FAIL dec64_vs32_illegal[%0d] got %b want %b", i, o32_illegal, vill32[i]);
            end
        end
        step();
    endtask

    task automatic test_stall_hold();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00112423;
        in_pc32   = 32'h0000_3000;
        step();
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o32_valid !== 1'b1 || o32_instr !== 32'h00112423 || o32_imm !== 32'h8 || o32_pc !== 32'h0000_3000) begin
                errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b instr=%h imm=%h pc=%h want 1/00112423/8/3000", i, o32_valid, o32_instr, o32_imm, o32_pc);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got %b want 0", o32_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] beats [4];
        int sent;
        int rcvd;
        beats = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 20 && rcvd < 4; cyc++) begin
            in_valid  = (sent < 4);
            in_instr  = (sent < 4) ? beats[sent] : 32'h0;
            in_pc32   = 32'h0000_0100 + 32'(sent * 4);
            out_ready = (cyc >= 2);
            if (cyc == 2) begin
                checks++; if (in_ready32 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_in_ready_drop got %b want 0", in_ready32); end
            end
            if (o32_valid && out_ready) begin
                checks++;
                if (o32_instr !== beats[rcvd] || o32_imm !== 32'(rcvd + 1) || o32_pc !== 32'h0000_0100 + 32'(rcvd * 4)) begin
                    errors++; $display("[TB] FAIL b2b_order[%0d] got instr=%h imm=%h pc=%h want %h/%h", rcvd, o32_instr, o32_imm, o32_pc, beats[rcvd], 32'(rcvd + 1));
                end
                rcvd++;
            end
            if (in_valid && in_ready32) sent++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (rcvd != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", rcvd); end
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_dup got %b want 0", o32_valid); end
        step();
        checks++; if (o32_valid !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_idle got valid=%b ready=%b want 0/1", o32_valid, in_ready32);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A00093;
        step();
        in_instr  = 32'h00B00093;
        step();
        checks++; if (in_ready32 !== 1'b0) begin errors++; $display("[TB] FAIL flush_setup_full got %b want 0", in_ready32); end
        flush    = 1'b1;
        in_instr = 32'h00C00093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_valid got %b want 0", o32_valid); end
        checks++; if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL flush_full_ready got %b want 1", in_ready32); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_ghost[%0d] got %b want 0", i, o32_valid); end
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00D00093;
        step();
        flush    = 1'b1;
        in_instr = 32'h00E00093;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (o32_valid !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_drop_offer got valid=%b ready=%b want 0/1", o32_valid, in_ready32);
        end
        step();
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_ghost got %b instr=%h want 0", o32_valid, o32_instr); end
    endtask

    task automatic test_reset_dominates();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_pc32   = 32'h0000_4000;
        step();
        in_instr  = 32'h00600093;
        step();
        rst   = 1'b1;
        flush = 1'b1;
        in_instr = 32'h00700093;
        step();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (o32_valid !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_state got valid=%b ready=%b want 0/1", o32_valid, in_ready32);
        end
        checks++; if (o32_imm !== 32'h0 || o32_instr !== 32'h0 || o32_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL rst_mid_payload got imm=%h instr=%h pc=%h want 0", o32_imm, o32_instr, o32_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o32_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_reissue[%0d] got %b want 0", i, o32_valid); end
        end
    endtask

    task automatic test_zicsr();
        logic [31:0] exp_imm_w;
        logic [2:0]  exp_fmt_w;
        logic        exp_ill_w;
        logic [31:0] exp_imm_s;
        logic [2:0]  exp_fmt_s;
        logic        exp_ill_s;
`ifdef DECODE_IMM_ZICSR_EN
        exp_imm_w = 32'h3;   exp_fmt_w = 3'd6; exp_ill_w = 1'b0;
        exp_imm_s = 32'h340; exp_fmt_s = 3'd1; exp_ill_s = 1'b0;
`else
        exp_imm_w = 32'h0;   exp_fmt_w = 3'd7; exp_ill_w = 1'b1;
        exp_imm_s = 32'h0;   exp_fmt_s = 3'd7; exp_ill_s = 1'b1;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3401D073;
        step();
        in_instr  = 32'h34011073;
        checks++; if (o32_valid !== 1'b1 || o32_imm !== exp_imm_w || o32_fmt !== exp_fmt_w || o32_illegal !== exp_ill_w) begin
            errors++; $display("[TB] FAIL csrrwi got v=%b imm=%h fmt=%0d ill=%b want 1/%h/%0d/%b", o32_valid, o32_imm, o32_fmt, o32_illegal, exp_imm_w, exp_fmt_w, exp_ill_w);
        end
        step();
        in_valid = 1'b0;
        checks++; if (o32_valid !== 1'b1 || o32_imm !== exp_imm_s || o32_fmt !== exp_fmt_s || o32_illegal !== exp_ill_s) begin
            errors++; $display("[TB] FAIL csrrw got v=%b imm=%h fmt=%0d ill=%b want 1/%h/%0d/%b", o32_valid, o32_imm, o32_fmt, o32_illegal, exp_imm_s, exp_fmt_s, exp_ill_s);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_decode32();
        test_xlen64();
        test_stall_hold();
        test_back_to_back();
        test_flush();
        test_reset_dominates();
        test_zicsr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
